// File: rtl/inst_loader_if.sv
// Bus bundle between the byte source and the instruction-memory write port.
// The slave modport faces the loader; the master modport faces the driver.
interface inst_loader_if #(
  parameter int ADDR_WIDTH = 10
);
  logic                  start_i;
  logic                  byte_valid_i;
  logic [7:0]            byte_data_i;
  logic                  byte_ready_o;
  logic                  mem_we_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [31:0]           mem_data_o;
  logic                  core_rst_o;
  logic                  done_o;
  logic                  error_o;

  modport master (
    output start_i, byte_valid_i, byte_data_i,
    input  byte_ready_o, mem_we_o, mem_addr_o, mem_data_o,
           core_rst_o, done_o, error_o
  );

  modport slave (
    input  start_i, byte_valid_i, byte_data_i,
    output byte_ready_o, mem_we_o, mem_addr_o, mem_data_o,
           core_rst_o, done_o, error_o
  );
endinterface

// File: rtl/inst_loader.sv
// Streams a program image (16-bit count, big-endian words, XOR checksum) into instruction
// memory and holds the core in reset until it verifies. Optional idle timeout: INST_LOADER_TIMEOUT_EN.
module inst_loader #(
  parameter int ADDR_WIDTH     = 10,
  parameter int BASE_ADDR      = 0,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input logic         clk,
  input logic         rst,
  inst_loader_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    CNT_HI,
    CNT_LO,
    DATA,
    CSUM,
    DONE,
    ERR
  } state_t;

  // Largest word count that still fits between BASE_ADDR and the top of memory.
  localparam logic [16:0] MAX_WORDS = 17'((1 << ADDR_WIDTH) - BASE_ADDR);

  if (ADDR_WIDTH < 1 || ADDR_WIDTH > 16 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_params
    $error("inst_loader: ADDR_WIDTH must be 1..16 and TIMEOUT_CYCLES 1..65535");
  end

  state_t                state;
  state_t                next_state;
  logic [15:0]           count;
  logic [15:0]           count_next;
  logic [15:0]           word_idx;
  logic [1:0]            byte_sel;
  logic [23:0]           shift;
  logic [7:0]            xor_acc;
  logic                  loading;
  logic                  rearm;
  logic                  accept;
  logic                  timed_out;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_data;

  assign loading    = (state == CNT_HI) || (state == CNT_LO) || (state == DATA) || (state == CSUM);
  assign rearm      = !loading && bus.start_i;
  assign accept     = loading && bus.byte_valid_i;
  assign count_next = {count[15:8], bus.byte_data_i};

  assign bus.byte_ready_o = loading;
  assign bus.done_o       = (state == DONE);
  assign bus.error_o      = (state == ERR);
  assign bus.core_rst_o   = (state == DONE);
  assign bus.mem_we_o     = mem_we;
  assign bus.mem_addr_o   = mem_addr;
  assign bus.mem_data_o   = mem_data;

`ifdef INST_LOADER_TIMEOUT_EN
  logic [15:0] idle_cnt;

  // Idle cycles since the last accepted byte; idle states keep it at zero so a fresh load starts clean.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idle_cnt <= '0;
    end else if (accept || !loading) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 16'd1;
    end
  end

  assign timed_out = loading && !accept && (idle_cnt == 16'(TIMEOUT_CYCLES));
`else
  assign timed_out = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE, ERR: begin
        if (bus.start_i) next_state = CNT_HI;
      end
      CNT_HI: begin
        if (accept) next_state = CNT_LO;
      end
      CNT_LO: begin
        if (accept) begin
          if ({1'b0, count_next} > MAX_WORDS) next_state = ERR;
          else if (count_next == 16'd0)       next_state = CSUM;
          else                                next_state = DATA;
        end
      end
      DATA: begin
        if (accept && byte_sel == 2'd3 && word_idx == count - 16'd1) next_state = CSUM;
      end
      CSUM: begin
        if (accept) next_state = (bus.byte_data_i == xor_acc) ? DONE : ERR;
      end
      default: next_state = IDLE;
    endcase
    if (timed_out) next_state = ERR;
  end

  // Byte datapath: count capture, word assembly and the one-cycle memory write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count    <= '0;
      word_idx <= '0;
      byte_sel <= '0;
      shift    <= '0;
      xor_acc  <= '0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
    end else begin
      mem_we <= 1'b0;
      if (rearm) begin
        xor_acc  <= '0;
        word_idx <= '0;
        byte_sel <= '0;
      end
      if (accept) begin
        if (state != CSUM) xor_acc <= xor_acc ^ bus.byte_data_i;
        case (state)
          CNT_HI: count[15:8] <= bus.byte_data_i;
          CNT_LO: count[7:0]  <= bus.byte_data_i;
          DATA: begin
            shift    <= {shift[15:0], bus.byte_data_i};
            byte_sel <= byte_sel + 2'd1;
            if (byte_sel == 2'd3) begin
              mem_we   <= 1'b1;
              mem_addr <= ADDR_WIDTH'(BASE_ADDR) + word_idx[ADDR_WIDTH-1:0];
              mem_data <= {shift, bus.byte_data_i};
              word_idx <= word_idx + 16'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader: a byte-position model predicts every output each cycle,
// and literal checks pin memory contents and final status after each stream.
module tb_inst_loader;

  localparam int AW   = 4;
  localparam int BASE = 0;
  localparam int TMO  = 100;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  inst_loader_if #(.ADDR_WIDTH(AW)) bus ();

  inst_loader #(
    .ADDR_WIDTH    (AW),
    .BASE_ADDR     (BASE),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;
  int writes   = 0;
  logic [31:0] mem [0:(1<<AW)-1];

  // Model state: position within the current stream rather than a state encoding.
  bit          m_active = 0;
  int          m_pos = 0;
  int          m_n = 0;
  int          m_idle = 0;
  logic [7:0]  m_xor = '0;
  logic [31:0] m_cur = '0;
  bit          m_acc;
  logic [7:0]  m_b;
  logic          exp_ready = 0, exp_we = 0, exp_done = 0, exp_err = 0, exp_core = 0;
  logic [AW-1:0] exp_addr = '0;
  logic [31:0]   exp_data = '0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic modelStep();
    if (!rst) begin
      m_active = 0; m_pos = 0; m_n = 0; m_idle = 0; m_xor = '0; m_cur = '0;
      exp_ready = 0; exp_we = 0; exp_done = 0; exp_err = 0; exp_core = 0;
      exp_addr = '0; exp_data = '0;
    end else begin
      m_acc = exp_ready && (bus.byte_valid_i === 1'b1);
      m_b   = bus.byte_data_i;
      exp_we = 0;
      if (!m_active) begin
        if (bus.start_i === 1'b1) begin
          m_active = 1; m_pos = 0; m_n = 0; m_xor = '0; m_idle = 0;
          exp_done = 0; exp_err = 0; exp_core = 0;
        end
      end else if (m_acc) begin
        m_idle = 0;
        if (m_pos == 0) begin
          m_n = int'(m_b) << 8;
        end else if (m_pos == 1) begin
          m_n = m_n | int'(m_b);
          if (m_n > (1 << AW) - BASE) begin m_active = 0; exp_err = 1; end
        end else if (m_pos == 2 + 4 * m_n) begin
          m_active = 0;
          if (m_b == m_xor) begin exp_done = 1; exp_core = 1; end
          else exp_err = 1;
        end else begin
          m_cur = {m_cur[23:0], m_b};
          if ((m_pos - 2) % 4 == 3) begin
            exp_we   = 1;
            exp_addr = AW'(BASE + (m_pos - 2) / 4);
            exp_data = m_cur;
          end
        end
        m_xor = m_xor ^ m_b;
        m_pos++;
      end else begin
`ifdef INST_LOADER_TIMEOUT_EN
        if (m_idle == TMO) begin m_active = 0; exp_err = 1; end
        else m_idle++;
`endif
      end
      exp_ready = m_active;
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst);
    modelStep();
  end

  // Per-cycle comparison against the model, plus a record of every memory write.
  initial forever begin
    @(negedge clk);
    if (bus.mem_we_o === 1'b1) begin
      mem[bus.mem_addr_o] = bus.mem_data_o;
      writes++;
    end
    checkOutput("cyc_ready", 32'(bus.byte_ready_o), 32'(exp_ready));
    checkOutput("cyc_we",    32'(bus.mem_we_o),     32'(exp_we));
    checkOutput("cyc_addr",  32'(bus.mem_addr_o),   32'(exp_addr));
    checkOutput("cyc_data",  bus.mem_data_o,        exp_data);
    checkOutput("cyc_done",  32'(bus.done_o),       32'(exp_done));
    checkOutput("cyc_err",   32'(bus.error_o),      32'(exp_err));
    checkOutput("cyc_core",  32'(bus.core_rst_o),   32'(exp_core));
  end

  function automatic logic [7:0] xorOf(input logic [7:0] q[$]);
    logic [7:0] x = '0;
    foreach (q[i]) x = x ^ q[i];
    return x;
  endfunction

  task automatic applyStimulus(input logic [7:0] b, input int gap);
    logic rdy;
    bus.byte_valid_i = 1'b0;
    repeat (gap) @(negedge clk);
    bus.byte_valid_i = 1'b1;
    bus.byte_data_i  = b;
    for (int i = 0; i < 200; i++) begin
      rdy = bus.byte_ready_o;
      @(negedge clk);
      if (rdy === 1'b1) return;
    end
    checks++;
    failures++;
    $display("[TB] FAIL handshake_timeout actual=no_accept expected=accept byte=%h", b);
  endtask

  task automatic sendStream(input logic [7:0] q[$], input int max_gap, input int start_at);
    foreach (q[i]) begin
      if (i == start_at) bus.start_i = 1'b1;
      applyStimulus(q[i], $urandom_range(0, max_gap));
      bus.start_i = 1'b0;
    end
    bus.byte_valid_i = 1'b0;
  endtask

  task automatic pulseStart();
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
  endtask

  task automatic settle();
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic checkStatus(input string tag, input logic done, input logic err, input logic core);
    checkOutput({tag, "_done"}, 32'(bus.done_o),     32'(done));
    checkOutput({tag, "_err"},  32'(bus.error_o),    32'(err));
    checkOutput({tag, "_core"}, 32'(bus.core_rst_o), 32'(core));
  endtask

  initial begin
    logic [7:0] q[$];
    int base_w;
    bus.start_i      = 1'b0;
    bus.byte_valid_i = 1'b0;
    bus.byte_data_i  = '0;
    repeat (3) @(negedge clk);
    #1;
    checkStatus("reset", 1'b0, 1'b0, 1'b0);
    checkOutput("reset_ready", 32'(bus.byte_ready_o), 32'd0);
    checkOutput("reset_we",    32'(bus.mem_we_o),     32'd0);
    checkOutput("reset_addr",  32'(bus.mem_addr_o),   32'd0);
    checkOutput("reset_data",  bus.mem_data_o,        32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Two-word image with a good checksum (0x20).
    base_w = writes;
    q = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67};
    checkOutput("csum_literal", 32'(xorOf(q)), 32'h20);
    q.push_back(8'h20);
    pulseStart();
    sendStream(q, 0, -1);
    settle();
    checkStatus("good", 1'b1, 1'b0, 1'b1);
    checkOutput("good_w0", mem[0], 32'hDEADBEEF);
    checkOutput("good_w1", mem[1], 32'h01234567);
    checkOutput("good_writes", 32'(writes - base_w), 32'd2);

    // Same image, checksum off by one bit.
    base_w = writes;
    q[10] = 8'h21;
    pulseStart();
    sendStream(q, 1, -1);
    settle();
    checkStatus("badcs", 1'b0, 1'b1, 1'b0);
    checkOutput("badcs_writes", 32'(writes - base_w), 32'd2);

    // Empty image.
    base_w = writes;
    pulseStart();
    sendStream('{8'h00, 8'h00, 8'h00}, 0, -1);
    settle();
    checkStatus("empty", 1'b1, 1'b0, 1'b1);
    checkOutput("empty_writes", 32'(writes - base_w), 32'd0);

    // Counts one past the memory size are refused right after the count bytes.
    base_w = writes;
    pulseStart();
    sendStream('{8'h00, 8'h11}, 0, -1);
    settle();
    checkStatus("ovf17", 1'b0, 1'b1, 1'b0);
    checkOutput("ovf17_ready", 32'(bus.byte_ready_o), 32'd0);
    pulseStart();
    sendStream('{8'h01, 8'h00}, 0, -1);
    settle();
    checkStatus("ovf256", 1'b0, 1'b1, 1'b0);
    checkOutput("ovf_writes", 32'(writes - base_w), 32'd0);

    // Full memory, with a stray start pulse mid-stream.
    base_w = writes;
    q = '{8'h00, 8'h10};
    for (int w = 0; w < 16; w++) begin
      q.push_back(8'(w)); q.push_back(8'(w + 16)); q.push_back(8'(w + 32)); q.push_back(8'(w + 48));
    end
    q.push_back(xorOf(q));
    pulseStart();
    sendStream(q, 1, 13);
    settle();
    checkStatus("full", 1'b1, 1'b0, 1'b1);
    checkOutput("full_w0",  mem[0],  32'h00102030);
    checkOutput("full_w15", mem[15], 32'h0F1F2F3F);
    checkOutput("full_writes", 32'(writes - base_w), 32'd16);
    checkOutput("full_last_addr", 32'(bus.mem_addr_o), 32'hF);

    // Random valid gaps, then reset in the middle of the second word.
    base_w = writes;
    q = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    pulseStart();
    sendStream(q, 3, -1);
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkStatus("inrst", 1'b0, 1'b0, 1'b0);
    checkOutput("inrst_ready", 32'(bus.byte_ready_o), 32'd0);
    rst = 1'b1;
    settle();
    checkStatus("postrst", 1'b0, 1'b0, 1'b0);
    checkOutput("postrst_ready", 32'(bus.byte_ready_o), 32'd0);
    checkOutput("postrst_addr",  32'(bus.mem_addr_o),   32'd0);
    checkOutput("postrst_data",  bus.mem_data_o,        32'd0);
    checkOutput("rst_w0",        mem[0],                32'h11223344);
    checkOutput("rst_writes",    32'(writes - base_w),  32'd1);

    // Long stall mid-word.
    base_w = writes;
    pulseStart();
    sendStream('{8'h00, 8'h01, 8'hAA, 8'hBB}, 0, -1);
    repeat (150) @(negedge clk);
`ifdef INST_LOADER_TIMEOUT_EN
    #1;
    checkStatus("stall", 1'b0, 1'b1, 1'b0);
    checkOutput("stall_writes", 32'(writes - base_w), 32'd0);
`else
    sendStream('{8'hCC, 8'hDD, 8'h01}, 0, -1);
    settle();
    checkStatus("stall", 1'b1, 1'b0, 1'b1);
    checkOutput("stall_w0", mem[0], 32'hAABBCCDD);
`endif

    settle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
